// File: rtl/health_bar_ctrl_if.sv
// Pixel-side bundle for the health-bar generator: raster coordinates and health
// values in, registered per-pixel flags out.
interface health_bar_ctrl_if #(
    parameter int HEALTH_W = 8
);
    logic [9:0]          DrawX;
    logic [9:0]          DrawY;
    logic                blank;
    logic [HEALTH_W-1:0] RyuHealth;
    logic [HEALTH_W-1:0] AkumaHealth;
    logic                health_on;
    logic                ghost_on;
    logic                ko;

    modport master (
        output DrawX, DrawY, blank, RyuHealth, AkumaHealth,
        input  health_on, ghost_on, ko
    );

    modport slave (
        input  DrawX, DrawY, blank, RyuHealth, AkumaHealth,
        output health_on, ghost_on, ko
    );
endinterface

// File: rtl/health_bar_ctrl.sv
// Two-player health bars with frame-latched health, draining ghost trail and
// low-health blink; emits registered live/ghost pixel flags plus a KO flag.
module health_bar_ctrl #(
    parameter int HEALTH_W   = 8,
    parameter int LEFT_X     = 40,
    parameter int RIGHT_X    = 600,
    parameter int Y_TOP      = 20,
    parameter int Y_BOT      = 30,
    parameter int DRAIN_DIV  = 2,
    parameter int LOW_THRESH = 32,
    parameter int BLINK_HALF = 16
) (
    input  logic             vga_clk,
    input  logic             Reset_n,
    health_bar_ctrl_if.slave pix
);
    localparam logic [9:0]          LX         = 10'(LEFT_X);
    localparam logic [9:0]          RX         = 10'(RIGHT_X);
    localparam logic [9:0]          YT         = 10'(Y_TOP);
    localparam logic [9:0]          YB         = 10'(Y_BOT);
    localparam logic [7:0]          DRAIN_LAST = 8'(DRAIN_DIV - 1);
    localparam logic [7:0]          BLINK_LAST = 8'(BLINK_HALF - 1);
    localparam logic [31:0]         LOW_C      = 32'(LOW_THRESH);
    localparam logic [HEALTH_W-1:0] ONE_H      = 1;

    // A full-scale bar must stay on screen without the 10-bit sums wrapping.
    if (LEFT_X + 2**HEALTH_W - 1 > 1023) begin : g_bad_left
        $error("health_bar_ctrl: LEFT_X too large for HEALTH_W");
    end
    if (RIGHT_X < 2**HEALTH_W - 1) begin : g_bad_right
        $error("health_bar_ctrl: RIGHT_X too small for HEALTH_W");
    end
    if (DRAIN_DIV < 1 || DRAIN_DIV > 255) begin : g_bad_drain
        $error("health_bar_ctrl: DRAIN_DIV out of range");
    end
    if (BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_bad_blink
        $error("health_bar_ctrl: BLINK_HALF out of range");
    end

    logic                match_q, tick_q;
    logic [HEALTH_W-1:0] h1_q, h2_q, g1_q, g2_q, g1_d, g2_d;
    logic [7:0]          drain_q, drain_d, blink_q, blink_d;
    logic                phase_q, phase_d;
    logic                health_q, health_d, ghost_q, ghost_d, ko_q;

    logic                coord_zero, frame_tick, drain_hit, blink_wrap;
    logic [9:0]          p1_live_end, p1_ghost_end, p2_live_beg, p2_ghost_beg;
    logic                in_rows, low1, low2, live1, live2, trail1, trail2;

    function automatic logic [HEALTH_W-1:0] ghost_next(
        input logic [HEALTH_W-1:0] h_new,
        input logic [HEALTH_W-1:0] g_cur,
        input logic                dec
    );
        logic [HEALTH_W-1:0] g_nxt;
        g_nxt = g_cur;
        if (h_new >= g_cur) begin
            g_nxt = h_new;
        end else if (dec) begin
            g_nxt = g_cur - ONE_H;
        end
        return g_nxt;
    endfunction

    always_comb begin
        coord_zero   = (pix.DrawX == 10'd0) && (pix.DrawY == 10'd0);
        frame_tick   = coord_zero && !match_q;
        drain_hit    = (drain_q == DRAIN_LAST);
        blink_wrap   = (blink_q == BLINK_LAST);
        g1_d         = ghost_next(pix.RyuHealth, g1_q, drain_hit);
        g2_d         = ghost_next(pix.AkumaHealth, g2_q, drain_hit);
        drain_d      = drain_hit ? 8'd0 : drain_q + 8'd1;
        blink_d      = blink_wrap ? 8'd0 : blink_q + 8'd1;
        phase_d      = phase_q ^ blink_wrap;

        p1_live_end  = LX + 10'(h1_q);
        p1_ghost_end = LX + 10'(g1_q);
        p2_live_beg  = RX - 10'(h2_q);
        p2_ghost_beg = RX - 10'(g2_q);

        in_rows = (pix.DrawY >= YT) && (pix.DrawY < YB);
        low1    = (32'(h1_q) < LOW_C) && phase_q;
        low2    = (32'(h2_q) < LOW_C) && phase_q;
        live1   = in_rows && (pix.DrawX >= LX) && (pix.DrawX < p1_live_end) && !low1;
        trail1  = in_rows && (pix.DrawX >= p1_live_end) && (pix.DrawX < p1_ghost_end);
        live2   = in_rows && (pix.DrawX >= p2_live_beg) && (pix.DrawX < RX) && !low2;
        trail2  = in_rows && (pix.DrawX >= p2_ghost_beg) && (pix.DrawX < p2_live_beg);

        health_d = pix.blank && (live1 || live2);
        ghost_d  = pix.blank && (trail1 || trail2) && !health_d;
    end

    always_ff @(posedge vga_clk) begin
        if (!Reset_n) begin
            match_q  <= 1'b0;
            tick_q   <= 1'b0;
            h1_q     <= '0;
            h2_q     <= '0;
            g1_q     <= '0;
            g2_q     <= '0;
            drain_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            health_q <= 1'b0;
            ghost_q  <= 1'b0;
            ko_q     <= 1'b0;
        end else begin
            match_q  <= coord_zero;
            tick_q   <= frame_tick;
            health_q <= health_d;
            ghost_q  <= ghost_d;
            if (frame_tick) begin
                h1_q    <= pix.RyuHealth;
                h2_q    <= pix.AkumaHealth;
                g1_q    <= g1_d;
                g2_q    <= g2_d;
                drain_q <= drain_d;
                blink_q <= blink_d;
                phase_q <= phase_d;
            end
            // KO follows the freshly latched healths one cycle after the tick.
            if (tick_q) begin
                ko_q <= (h1_q == '0) || (h2_q == '0);
            end
        end
    end

    assign pix.health_on = health_q;
    assign pix.ghost_on  = ghost_q;
    assign pix.ko        = ko_q;
endmodule

// File: tb/tb_health_bar_ctrl.sv
// Scoreboard bench for health_bar_ctrl: a behavioural model predicts each
// pixel's flags, which are queued on drive and compared as outputs appear.
module tb_health_bar_ctrl;
    localparam int DRAIN_DIV  = 2;
    localparam int BLINK_HALF = 16;

    typedef struct {
        bit h;
        bit g;
        bit k;
        int x;
        bit cnt;
    } exp_t;

    logic vga_clk = 1'b0;
    logic Reset_n;

    health_bar_ctrl_if #(.HEALTH_W(8)) pix();

    health_bar_ctrl dut (
        .vga_clk (vga_clk),
        .Reset_n (Reset_n),
        .pix     (pix)
    );

    always #5 vga_clk = ~vga_clk;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    int m_h1, m_h2, m_g1, m_g2, m_drain, m_blink;
    bit m_phase, m_match, m_tickp, m_ko;
    bit cnt_en;
    int p1_h, p1_g, p2_h, p2_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_g1 = 0; m_g2 = 0;
        m_drain = 0; m_blink = 0;
        m_phase = 0; m_match = 0; m_tickp = 0; m_ko = 0;
    endtask

    task automatic step(input int x, input int y, input bit b, input bit rst_n);
        exp_t e;
        bit zero, tick, row, l1, l2, gh1, gh2;
        int nh1, nh2;
        pix.DrawX = 10'(x);
        pix.DrawY = 10'(y);
        pix.blank = b;
        Reset_n   = rst_n;
        e.x   = x;
        e.cnt = cnt_en;
        if (!rst_n) begin
            e.h = 0; e.g = 0; e.k = 0;
            model_reset();
        end else begin
            zero = (x == 0) && (y == 0);
            tick = zero && !m_match;
            e.k  = m_tickp ? ((m_h1 == 0) || (m_h2 == 0)) : m_ko;
            row  = (y >= 20) && (y < 30);
            l1   = (x >= 40) && (x < 40 + m_h1) && !((m_h1 < 32) && m_phase);
            gh1  = (x >= 40 + m_h1) && (x < 40 + m_g1);
            l2   = (x >= 600 - m_h2) && (x < 600) && !((m_h2 < 32) && m_phase);
            gh2  = (x >= 600 - m_g2) && (x < 600 - m_h2);
            e.h  = b && row && (l1 || l2);
            e.g  = b && row && (gh1 || gh2) && !e.h;
            m_ko    = e.k;
            m_match = zero;
            m_tickp = tick;
            if (tick) begin
                nh1 = int'(pix.RyuHealth);
                nh2 = int'(pix.AkumaHealth);
                if (nh1 >= m_g1) m_g1 = nh1;
                else if (m_drain == DRAIN_DIV - 1) m_g1 = m_g1 - 1;
                if (nh2 >= m_g2) m_g2 = nh2;
                else if (m_drain == DRAIN_DIV - 1) m_g2 = m_g2 - 1;
                m_h1 = nh1;
                m_h2 = nh2;
                m_drain = (m_drain == DRAIN_DIV - 1) ? 0 : m_drain + 1;
                if (m_blink == BLINK_HALF - 1) begin
                    m_blink = 0;
                    m_phase = !m_phase;
                end else begin
                    m_blink = m_blink + 1;
                end
            end
        end
        @(posedge vga_clk);
        sb_q.push_back(e);
        #1;
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("health_on", 32'(pix.health_on), 32'(e.h));
            chk("ghost_on", 32'(pix.ghost_on), 32'(e.g));
            chk("ko", 32'(pix.ko), 32'(e.k));
            if (e.cnt) begin
                if (e.x < 320) begin
                    p1_h += int'(pix.health_on);
                    p1_g += int'(pix.ghost_on);
                end else begin
                    p2_h += int'(pix.health_on);
                    p2_g += int'(pix.ghost_on);
                end
            end
        end
    end

    task automatic clr();
        p1_h = 0; p1_g = 0; p2_h = 0; p2_g = 0;
    endtask

    task automatic row(input int y, input int stp);
        for (int x = 0; x < 640; x += stp) step(x, y, 1'b1, 1'b1);
    endtask

    // Coordinate (0,0) is held two clocks to exercise the single-tick guard.
    task automatic frame(input bit full);
        step(0, 0, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b1);
        row(19, 37);
        cnt_en = 1'b1;
        row(25, full ? 1 : 7);
        cnt_en = 1'b0;
        row(29, 13);
        row(30, 11);
        step(50, 25, 1'b0, 1'b1);
        step(5, 5, 1'b1, 1'b1);
    endtask

    initial begin
        int k1, k2, n2;
        bit vis [70];
        pix.DrawX = 10'd100;
        pix.DrawY = 10'd25;
        pix.blank = 1'b1;
        pix.RyuHealth   = 8'd100;
        pix.AkumaHealth = 8'd200;
        Reset_n = 1'b0;
        cnt_en  = 1'b0;
        model_reset();
        clr();

        repeat (3) step(100, 25, 1'b1, 1'b0);
        chk("rst_health", 32'(pix.health_on), 32'd0);
        chk("rst_ko", 32'(pix.ko), 32'd0);
        step(100, 25, 1'b1, 1'b1);
        chk("pre_tick_empty", 32'(pix.health_on), 32'd0);

        clr(); frame(1'b1);
        chk("init_p1_live", p1_h, 100);
        chk("init_p1_ghost", p1_g, 0);
        chk("init_p2_live", p2_h, 200);
        chk("init_ko", 32'(pix.ko), 32'd0);

        frame(1'b0);
        pix.RyuHealth = 8'd90;
        clr(); frame(1'b1);
        chk("drain_p1_live", p1_h, 90);
        chk("drain_p1_ghost", p1_g, 10);
        repeat (19) frame(1'b0);
        clr(); frame(1'b1);
        chk("drained_ghost", p1_g, 0);
        repeat (3) frame(1'b0);
        clr(); frame(1'b1);
        chk("floor_live", p1_h, 90);
        chk("floor_ghost", p1_g, 0);

        pix.RyuHealth = 8'd100;
        frame(1'b0);
        pix.RyuHealth = 8'd90;
        for (int i = 0; i < 40 && m_g1 != 95; i++) frame(1'b0);
        pix.RyuHealth = 8'd120;
        clr(); frame(1'b1);
        chk("heal_live", p1_h, 120);
        chk("heal_ghost", p1_g, 0);

        step(0, 0, 1'b1, 1'b1);
        row(22, 13);
        for (int x = 0; x < 300; x += 3) step(x, 25, 1'b1, 1'b1);
        pix.AkumaHealth = 8'd50;
        for (int x = 300; x < 640; x += 3) step(x, 25, 1'b1, 1'b1);
        clr();
        cnt_en = 1'b1;
        row(26, 1);
        cnt_en = 1'b0;
        step(5, 5, 1'b1, 1'b1);
        chk("midframe_p2_live", p2_h, 200);
        clr(); frame(1'b1);
        chk("after_tick_p2_live", p2_h, 50);

        pix.RyuHealth = 8'd20;
        n2 = 0; k1 = -1; k2 = -1;
        for (int i = 0; i < 70; i++) begin
            clr(); frame(1'b0);
            vis[i] = (p1_h > 0);
            if (p2_h > 0) n2++;
        end
        for (int i = 1; i < 70; i++) begin
            if (vis[i] != vis[i-1]) begin
                if (k1 < 0) k1 = i;
                else if (k2 < 0) k2 = i;
            end
        end
        chk("blink_half_period", 32'(k2 - k1), 32'd16);
        chk("blink_p2_visible", n2, 70);

        pix.RyuHealth   = 8'd100;
        pix.AkumaHealth = 8'd0;
        clr(); frame(1'b1);
        chk("ko_set", 32'(pix.ko), 32'd1);
        chk("ko_p2_live", p2_h, 0);
        step(60, 25, 1'b1, 1'b1);
        chk("blank_pre", 32'(pix.health_on), 32'd1);
        step(60, 25, 1'b0, 1'b1);
        chk("blank_gate", 32'(pix.health_on), 32'd0);

        pix.AkumaHealth = 8'd200;
        step(0, 0, 1'b1, 1'b1);
        row(22, 13);
        repeat (3) step(70, 25, 1'b1, 1'b0);
        chk("rst2_ko_clear", 32'(pix.ko), 32'd0);
        chk("rst2_health", 32'(pix.health_on), 32'd0);
        step(71, 25, 1'b1, 1'b1);
        step(5, 26, 1'b1, 1'b1);
        clr(); frame(1'b1);
        chk("rst2_p1_live", p1_h, 100);
        chk("rst2_p1_ghost", p1_g, 0);
        chk("rst2_p2_live", p2_h, 200);
        chk("rst2_ko", 32'(pix.ko), 32'd0);

        step(5, 5, 1'b1, 1'b1);
        repeat (2) @(posedge vga_clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
